// File: rtl/exec_lanes.sv
// N-lane execute stage: per-lane ALU with registered results toward the memory stage.
// Optional EXEC_MUL_EN adds a multi-cycle multiply that holds upstream through ex_busy.

module exec_lane_alu #(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res
);
    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] prod;

    assign sh = b[SHW-1:0];
    // Low XLEN bits of a product are identical for signed and unsigned operands.
    assign prod = $signed(a) * $signed(b);

    always_comb begin
        res = b;
        case (op)
            4'd1:    res = a + b;
            4'd2:    res = a - b;
            4'd3:    res = $signed(a) >>> sh;
            4'd4:    res = a << sh;
            4'd5:    res = a >> sh;
            4'd6:    res = a & b;
            4'd7:    res = a | b;
            4'd8:    res = a ^ b;
            4'd9:    res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef EXEC_MUL_EN
            4'd10:   res = prod;
`endif
            default: res = b;
        endcase
    end

`ifndef EXEC_MUL_EN
    logic unused_prod;
    assign unused_prod = ^prod;
`endif
endmodule

module exec_lanes #(
    parameter int LANES   = 2,
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  interlock,
    output logic                  ex_busy,
    output logic                  ex_to_mem_ready,
    input  logic [32*LANES-1:0]   inst,
    input  logic [XLEN*LANES-1:0] srca,
    input  logic [XLEN*LANES-1:0] srcb,
    input  logic [XLEN*LANES-1:0] srcs,
    input  logic [4*LANES-1:0]    e_type,
    input  logic [5*LANES-1:0]    rt,
    input  logic [LANES-1:0]      rt_flag,
    output logic [32*LANES-1:0]   inst_to_the_next,
    output logic [XLEN*LANES-1:0] tdata,
    output logic [XLEN*LANES-1:0] sdata,
    output logic [5*LANES-1:0]    rt_to_the_next,
    output logic [LANES-1:0]      rt_flag_to_the_next
);
    localparam logic [31:0] BUBBLE = {3'b111, 29'b0};
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [32*LANES-1:0]     cap_inst_q, cap_inst_d;
    logic [XLEN*LANES-1:0]   cap_a_q, cap_a_d, cap_b_q, cap_b_d, cap_s_q, cap_s_d;
    logic [4*LANES-1:0]      cap_op_q, cap_op_d;
    logic [5*LANES-1:0]      cap_rt_q, cap_rt_d;
    logic [LANES-1:0]        cap_flag_q, cap_flag_d;

    logic [32*LANES-1:0]     inst_q, inst_d;
    logic [XLEN*LANES-1:0]   tdata_q, tdata_d, sdata_q, sdata_d;
    logic [5*LANES-1:0]      rt_q, rt_d;
    logic [LANES-1:0]        flag_q, flag_d;
    logic                    ready_q, ready_d;

    // While busy the lanes evaluate the captured bundle; otherwise the live inputs.
    logic                    use_cap;
    logic [32*LANES-1:0]     sel_inst;
    logic [XLEN*LANES-1:0]   sel_a, sel_b, sel_s, res;
    logic [4*LANES-1:0]      sel_op;
    logic [5*LANES-1:0]      sel_rt;
    logic [LANES-1:0]        sel_flag, lane_load, lane_mul;
    logic                    any_mul, emit;

    assign use_cap  = (state_q == S_BUSY);
    assign sel_inst = use_cap ? cap_inst_q : inst;
    assign sel_a    = use_cap ? cap_a_q    : srca;
    assign sel_b    = use_cap ? cap_b_q    : srcb;
    assign sel_s    = use_cap ? cap_s_q    : srcs;
    assign sel_op   = use_cap ? cap_op_q   : e_type;
    assign sel_rt   = use_cap ? cap_rt_q   : rt;
    assign sel_flag = use_cap ? cap_flag_q : rt_flag;

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            exec_lane_alu #(.XLEN(XLEN)) u_alu (
                .op  (sel_op[4*k +: 4]),
                .a   (sel_a[XLEN*k +: XLEN]),
                .b   (sel_b[XLEN*k +: XLEN]),
                .res (res[XLEN*k +: XLEN])
            );
            assign lane_load[k] = (sel_inst[32*k+26 +: 6] == 6'b010000);
            assign lane_mul[k]  = (e_type[4*k +: 4] == 4'd10);
        end
    endgenerate

`ifdef EXEC_MUL_EN
    assign any_mul = |lane_mul;
    assign ex_busy = (state_q == S_BUSY);
`else
    assign any_mul = 1'b0;
    assign ex_busy = 1'b0;
    logic unused_mul;
    assign unused_mul = ^lane_mul;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_inst_d = cap_inst_q;
        cap_a_d    = cap_a_q;
        cap_b_d    = cap_b_q;
        cap_s_d    = cap_s_q;
        cap_op_d   = cap_op_q;
        cap_rt_d   = cap_rt_q;
        cap_flag_d = cap_flag_q;
        emit       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!interlock) begin
                    if (any_mul) begin
                        cap_inst_d = inst;
                        cap_a_d    = srca;
                        cap_b_d    = srcb;
                        cap_s_d    = srcs;
                        cap_op_d   = e_type;
                        cap_rt_d   = rt;
                        cap_flag_d = rt_flag;
                        cnt_d      = CW'(MUL_LAT - 1);
                        state_d    = S_BUSY;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    emit    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Any cycle that does not emit a bundle sends bubbles; data fields hold.
        inst_d  = {LANES{BUBBLE}};
        flag_d  = '0;
        ready_d = 1'b0;
        tdata_d = tdata_q;
        sdata_d = sdata_q;
        rt_d    = rt_q;
        if (emit) begin
            inst_d  = sel_inst;
            flag_d  = sel_flag;
            ready_d = |lane_load;
            tdata_d = res;
            sdata_d = sel_s;
            rt_d    = sel_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cap_inst_q <= '0;
            cap_a_q    <= '0;
            cap_b_q    <= '0;
            cap_s_q    <= '0;
            cap_op_q   <= '0;
            cap_rt_q   <= '0;
            cap_flag_q <= '0;
            inst_q     <= {LANES{BUBBLE}};
            tdata_q    <= '0;
            sdata_q    <= '0;
            rt_q       <= '0;
            flag_q     <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_inst_q <= cap_inst_d;
            cap_a_q    <= cap_a_d;
            cap_b_q    <= cap_b_d;
            cap_s_q    <= cap_s_d;
            cap_op_q   <= cap_op_d;
            cap_rt_q   <= cap_rt_d;
            cap_flag_q <= cap_flag_d;
            inst_q     <= inst_d;
            tdata_q    <= tdata_d;
            sdata_q    <= sdata_d;
            rt_q       <= rt_d;
            flag_q     <= flag_d;
            ready_q    <= ready_d;
        end
    end

    assign inst_to_the_next    = inst_q;
    assign tdata               = tdata_q;
    assign sdata               = sdata_q;
    assign rt_to_the_next      = rt_q;
    assign rt_flag_to_the_next = flag_q;
    assign ex_to_mem_ready     = ready_q;
endmodule
